div_unit: RTL and testbench
===========================

# div_unit

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It performs the inverse of the combinational multiply path: the execute stage issues a division with a start pulse and stalls the pipeline while `busy` is high. The divider produces a quotient or remainder through a radix-2 restoring shift-subtract loop, taking one bit per cycle, and signals completion with a one-cycle `done` pulse. Divide-by-zero and signed overflow resolve early, per the RISC-V specification.

## Interface
Parameters: none. The op encodings `ALU_DIV`, `ALU_DIVU`, `ALU_REM` and `ALU_REMU` come from the shared ALU op definitions.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request a division; sampled only in IDLE.
- `kill`  in  1  pipeline flush; aborts any operation in flight.
- `alu_op`  in  4  op select; sampled with `start`.
- `operand1`  in  32  dividend; sampled with `start`.
- `operand2`  in  32  divisor; sampled with `start`.
- `busy`  out  1  high while in CALC.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  32  quotient or remainder; held until the next accepted start.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `start` is accepted only when `alu_op` is one of the four divide ops; `start` with any other op is ignored.
  - On acceptance, latch the op, `operand1` and `operand2`.
- Special cases, checked in the IDLE acceptance cycle; these go directly to DONE:
  - Divisor == 0: quotient = 0xFFFF_FFFF; remainder = dividend. This applies to both signed and unsigned ops.
  - Signed op with dividend 0x8000_0000 and divisor 0xFFFF_FFFF: quotient = 0x8000_0000; remainder = 0.
- Normal case, IDLE -> CALC:
  - For signed ops, latch the absolute values of both operands. Record `neg_q` = sign1 XOR sign2 and `neg_r` = sign1.
  - Clear the 32-bit partial remainder. Load the magnitude of the dividend into the quotient shift register. Set the 5-bit counter to 0.
- CALC, one iteration per cycle:
  - Form `trial` = {rem[30:0], q[31]} minus the divisor, computed 33 bits wide.
  - If `trial` is non-negative: rem = `trial[31:0]` and shift 1 into q.
  - Otherwise: rem = {rem[30:0], q[31]} and shift 0 into q.
  - After counter == 31 completes, go to DONE.
- DONE:
  - DIV/DIVU output the quotient; REM/REMU output the remainder.
  - For signed ops, negate the output (two's complement) when `neg_q` (quotient) or `neg_r` (remainder) is set.
  - Register the output into `result` on entry to DONE, and assert `done` for that single cycle.
  - The next state is always IDLE. `start` is ignored while in DONE.
- `kill`, synchronous and highest priority:
  - In CALC or DONE, the next state is IDLE. No `done` is produced and `result` is left unchanged.
  - In IDLE, `kill` blocks acceptance of a simultaneous `start`.
- Width rules: all arithmetic is 32-bit modulo 2^32, except the 33-bit trial subtract. The magnitude of 0x8000_0000 is 0x8000_0000, taken as unsigned.

## Timing
- Reset values: state = IDLE; `busy` = 0; `done` = 0; `result` = 0; internal registers = 0.
- Let cycle 0 be the cycle in which `start` is accepted.
- Normal latency:
  - CALC occupies cycles 1 to 32, with `busy` = 1.
  - DONE occurs in cycle 33, with `done` = 1 and `busy` = 0.
  - The unit is back in IDLE in cycle 34, where the earliest next `start` is accepted.
- Special-case latency: DONE in cycle 1, IDLE in cycle 2.
- Latency is fixed and independent of operand values, apart from the special cases.
- `busy` is 0 in IDLE and DONE. The pipeline holds `alu_op` and the operands stable only in cycle 0.
- Reset asserted mid-operation forces IDLE immediately, asynchronously, and every output returns to its reset value.

## Test plan
- DIVU 100 / 7: `done` in cycle 33 with `result` = 14. REMU on the same operands gives 2. `busy` is high in exactly cycles 1 to 32.
- DIV -7 / 2 gives 0xFFFF_FFFD (-3); REM -7 / 2 gives 0xFFFF_FFFF (-1). DIV 7 / -2 gives -3; REM 7 / -2 gives 1.
- Divide by zero: DIVU 0x1234 / 0 gives 0xFFFF_FFFF in cycle 1. REM 0x8000_0001 / 0 gives 0x8000_0001 in cycle 1.
- Overflow: DIV 0x8000_0000 / 0xFFFF_FFFF gives 0x8000_0000 in cycle 1; REM on the same operands gives 0. DIVU 0x8000_0000 / 0xFFFF_FFFF takes the full loop and gives 0.
- `kill` in cycle 10 of a DIVU: IDLE in cycle 11, no `done` pulse, `result` keeps its previous value. A new `start` in cycle 11 completes normally in cycle 44.
- `start` asserted during CALC and DONE, and `start` with `ALU_ADD` in IDLE, are all ignored. Asserting `rst` in cycle 5 clears `busy`, `done` and `result` with no clock edge.

Source files
------------

// File: rtl/div_unit.sv
// Shared ALU op encodings plus the iterative radix-2 restoring divider used by
// the execute stage for DIV/DIVU/REM/REMU; one quotient bit per cycle.
package alu_pkg;
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_MUL  = 4'h7;
    localparam logic [3:0] ALU_DIV  = 4'h8;
    localparam logic [3:0] ALU_DIVU = 4'h9;
    localparam logic [3:0] ALU_REM  = 4'hA;
    localparam logic [3:0] ALU_REMU = 4'hB;
endpackage

module div_unit
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        kill,
    input  logic [3:0]  alu_op,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t      state, state_next;
    logic        op_rem, op_signed, neg_q, neg_r;
    logic [31:0] divisor, rem, quo;
    logic [4:0]  cnt;

    logic        is_div_op, accept, in_signed, in_rem;
    logic        div_zero, ovf, special;
    logic [31:0] special_res, abs1, abs2;
    logic [31:0] shifted, rem_next, quo_next, mag, final_res;
    logic [32:0] trial;
    logic        trial_ok, last_iter;

    // Request decode and early-out cases, evaluated in the acceptance cycle
    always_comb begin
        is_div_op = (alu_op == ALU_DIV) || (alu_op == ALU_DIVU) ||
                    (alu_op == ALU_REM) || (alu_op == ALU_REMU);
        accept    = (state == S_IDLE) && start && is_div_op && !kill;
        in_signed = (alu_op == ALU_DIV) || (alu_op == ALU_REM);
        in_rem    = (alu_op == ALU_REM) || (alu_op == ALU_REMU);
        div_zero  = (operand2 == 32'd0);
        ovf       = in_signed && (operand1 == 32'h8000_0000) && (operand2 == 32'hFFFF_FFFF);
        special   = div_zero || ovf;
        if (div_zero)
            special_res = in_rem ? operand1 : 32'hFFFF_FFFF;
        else
            special_res = in_rem ? 32'd0 : 32'h8000_0000;
        // 0x8000_0000 negates to itself, which reads correctly as unsigned
        abs1 = (in_signed && operand1[31]) ? (32'd0 - operand1) : operand1;
        abs2 = (in_signed && operand2[31]) ? (32'd0 - operand2) : operand2;
    end

    // One restoring step; the final step also feeds the result register directly
    always_comb begin
        shifted   = {rem[30:0], quo[31]};
        trial     = {1'b0, shifted} - {1'b0, divisor};
        trial_ok  = !trial[32];
        rem_next  = trial_ok ? trial[31:0] : shifted;
        quo_next  = {quo[30:0], trial_ok};
        last_iter = (cnt == 5'd31);
        mag       = op_rem ? rem_next : quo_next;
        if (op_signed && (op_rem ? neg_r : neg_q))
            final_res = 32'd0 - mag;
        else
            final_res = mag;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = special ? S_DONE : S_CALC;
            S_CALC: begin
                if (kill)
                    state_next = S_IDLE;
                else if (last_iter)
                    state_next = S_DONE;
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_rem    <= 1'b0;
            op_signed <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            divisor   <= 32'd0;
            rem       <= 32'd0;
            quo       <= 32'd0;
            cnt       <= 5'd0;
            result    <= 32'd0;
        end else if (accept) begin
            op_rem    <= in_rem;
            op_signed <= in_signed;
            neg_q     <= in_signed && (operand1[31] ^ operand2[31]);
            neg_r     <= in_signed && operand1[31];
            divisor   <= abs2;
            rem       <= 32'd0;
            quo       <= abs1;
            cnt       <= 5'd0;
            if (special)
                result <= special_res;
        end else if (state == S_CALC && !kill) begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 5'd1;
            if (last_iter)
                result <= final_res;
        end
    end

    assign busy = (state == S_CALC);
    // A flush landing in the DONE cycle suppresses the completion pulse
    assign done = (state == S_DONE) && !kill;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table for results/latency, plus
// hand-written sequences for kill, ignored starts and mid-operation reset.
module tb_div_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [3:0]  alu_op;
    logic [31:0] operand1, operand2;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    div_unit dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .alu_op(alu_op),
        .operand1(operand1), .operand2(operand2),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a request for the current cycle (cycle 0), then scramble inputs
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; alu_op = op; operand1 = a; operand2 = b;
        @(posedge clk);
        #1;
        start = 1'b0; alu_op = ALU_ADD; operand1 = $urandom; operand2 = $urandom;
    endtask

    // Count cycles to done; busy must be high in every cycle before it, low on it
    task automatic wait_done(output int lat, output logic [31:0] res, output int busy_bad);
        lat = -1; res = 32'hx; busy_bad = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k; res = result;
                if (busy) busy_bad++;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output int busy_bad);
        @(negedge clk);
        issue(op, a, b);
        wait_done(lat, res, busy_bad);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 400000");
        $fatal(1);
    end

    initial begin
        int lat, bb, act_cnt, done_cyc;
        logic [31:0] res, res_at_done;
        logic saw_done;

        vecs[0]  = '{ALU_DIVU, 32'd100,         32'd7,          32'd14,          33};
        vecs[1]  = '{ALU_REMU, 32'd100,         32'd7,          32'd2,           33};
        vecs[2]  = '{ALU_DIV,  32'hFFFF_FFF9,   32'd2,          32'hFFFF_FFFD,   33};
        vecs[3]  = '{ALU_REM,  32'hFFFF_FFF9,   32'd2,          32'hFFFF_FFFF,   33};
        vecs[4]  = '{ALU_DIV,  32'd7,           32'hFFFF_FFFE,  32'hFFFF_FFFD,   33};
        vecs[5]  = '{ALU_REM,  32'd7,           32'hFFFF_FFFE,  32'd1,           33};
        vecs[6]  = '{ALU_DIVU, 32'h1234,        32'd0,          32'hFFFF_FFFF,   1};
        vecs[7]  = '{ALU_REM,  32'h8000_0001,   32'd0,          32'h8000_0001,   1};
        vecs[8]  = '{ALU_DIV,  32'h8000_0000,   32'hFFFF_FFFF,  32'h8000_0000,   1};
        vecs[9]  = '{ALU_REM,  32'h8000_0000,   32'hFFFF_FFFF,  32'd0,           1};
        vecs[10] = '{ALU_DIVU, 32'h8000_0000,   32'hFFFF_FFFF,  32'd0,           33};
        vecs[11] = '{ALU_REMU, 32'h8000_0000,   32'hFFFF_FFFF,  32'h8000_0000,   33};
        vecs[12] = '{ALU_DIVU, 32'hFFFF_FFFF,   32'd1,          32'hFFFF_FFFF,   33};
        vecs[13] = '{ALU_DIV,  32'h8000_0000,   32'd2,          32'hC000_0000,   33};
        vecs[14] = '{ALU_REM,  32'hFFFF_FF9C,   32'd7,          32'hFFFF_FFFE,   33};
        vecs[15] = '{ALU_DIVU, 32'd0,           32'd5,          32'd0,           33};
        vecs[16] = '{ALU_DIV,  32'd5,           32'd0,          32'hFFFF_FFFF,   1};

        rst = 1'b1; start = 1'b0; kill = 1'b0; alu_op = ALU_ADD;
        operand1 = 32'd0; operand2 = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, bb);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_busy", i), 32'(bb), 32'd0);
        end

        // kill in cycle 10; result must still hold 100 from the prior op
        run_op(ALU_DIVU, 32'd1000, 32'd10, lat, res, bb);
        check("pre_kill_result", res, 32'd100);
        @(negedge clk);
        issue(ALU_DIVU, 32'd50, 32'd5);
        saw_done = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("kill_no_done_before", {31'd0, saw_done}, 32'd0);
        check("kill_busy_c11", {31'd0, busy}, 32'd0);
        check("kill_done_c11", {31'd0, done}, 32'd0);
        check("kill_result_held", result, 32'd100);
        issue(ALU_DIVU, 32'd50, 32'd5);
        wait_done(lat, res, bb);
        check("after_kill_latency", 32'(lat), 32'd33);
        check("after_kill_result", res, 32'd10);

        // start during CALC (cycle 5) and DONE (cycle 33) must be ignored
        @(negedge clk);
        issue(ALU_DIVU, 32'd100, 32'd7);
        done_cyc = -1; act_cnt = 0; res_at_done = 32'hx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done && done_cyc < 0) begin done_cyc = k; res_at_done = result; end
            if (k >= 34 && (busy || done)) act_cnt++;
            start = (k == 5 || k == 33);
            alu_op = ALU_DIVU; operand1 = 32'd9; operand2 = 32'd3;
        end
        start = 1'b0;
        check("ign_done_cycle", 32'(done_cyc), 32'd33);
        check("ign_result", res_at_done, 32'd14);
        check("ign_after_done", 32'(act_cnt), 32'd0);

        // non-divide op in IDLE, and start blocked by simultaneous kill
        @(negedge clk);
        start = 1'b1; alu_op = ALU_ADD; operand1 = 32'd10; operand2 = 32'd2;
        act_cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy || done) act_cnt++;
        end
        check("add_op_ignored", 32'(act_cnt), 32'd0);
        start = 1'b1; kill = 1'b1; alu_op = ALU_DIVU; operand1 = 32'd10; operand2 = 32'd2;
        act_cnt = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0; kill = 1'b0;
            if (busy || done) act_cnt++;
        end
        check("kill_blocks_start", 32'(act_cnt), 32'd0);
        check("kill_blocks_result", result, 32'd14);

        // asynchronous reset in cycle 5 of a running divide
        @(negedge clk);
        issue(ALU_DIVU, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        check("rst_pre_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        check("rst_async_done", {31'd0, done}, 32'd0);
        check("rst_async_result", result, 32'd0);
        #1 rst = 1'b0;
        run_op(ALU_REMU, 32'd100, 32'd7, lat, res, bb);
        check("post_rst_latency", 32'(lat), 32'd33);
        check("post_rst_result", res, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
